// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller:
// default widths, FSM state encodings and state-class helpers.
package modexp_ctrl_pkg;

  localparam int unsigned DEF_WIDTH     = 512;
  localparam int unsigned DEF_EXP_WIDTH = 512;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PRE    = 4'd1;
  localparam logic [3:0] ST_PRE_W  = 4'd2;
  localparam logic [3:0] ST_SQ     = 4'd3;
  localparam logic [3:0] ST_SQ_W   = 4'd4;
  localparam logic [3:0] ST_MUL    = 4'd5;
  localparam logic [3:0] ST_MUL_W  = 4'd6;
  localparam logic [3:0] ST_NEXT   = 4'd7;
  localparam logic [3:0] ST_POST   = 4'd8;
  localparam logic [3:0] ST_POST_W = 4'd9;
  localparam logic [3:0] ST_DONE   = 4'd10;

  // States that launch a multiply (mul_start high for their single cycle)
  function automatic logic is_issue(input logic [3:0] s);
    return (s == ST_PRE) || (s == ST_SQ) || (s == ST_MUL) || (s == ST_POST);
  endfunction

  function automatic logic is_wait(input logic [3:0] s);
    return (s == ST_PRE_W) || (s == ST_SQ_W) || (s == ST_MUL_W) || (s == ST_POST_W);
  endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier through a start/done handshake; owns operand muxing and accumulator.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     x_i,
  input  logic [EXP_WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0]     m_i,
  input  logic [WIDTH-1:0]     r_mod_m_i,
  input  logic [WIDTH-1:0]     r2_mod_m_i,
  output logic [WIDTH-1:0]     result_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 mul_start_o,
  output logic [WIDTH-1:0]     mul_a_o,
  output logic [WIDTH-1:0]     mul_b_o,
  output logic [WIDTH-1:0]     mul_m_o,
  input  logic [WIDTH+1:0]     mul_c_i,
  input  logic                 mul_done_i
);

  localparam int CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  logic [3:0]           state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d, m_q, m_d, r2_q, r2_d;
  logic [WIDTH-1:0]     acc_q, acc_d, xm_q, xm_d, result_q, result_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 armed_q, armed_d;
  logic [WIDTH-1:0]     prod;
  logic                 mul_ok;
  logic [1:0]           unused_mul_c_hi;

  assign prod            = mul_c_i[WIDTH-1:0];
  assign unused_mul_c_hi = mul_c_i[WIDTH+1:WIDTH];
  // armed_q masks mul_done during the first wait cycle, while the multiplier may still show the previous done
  assign mul_ok          = armed_q & mul_done_i;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    e_d      = e_q;
    m_d      = m_q;
    r2_d     = r2_q;
    acc_d    = acc_q;
    xm_d     = xm_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    armed_d  = is_wait(state_q);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          e_d     = e_i;
          m_d     = m_i;
          r2_d    = r2_mod_m_i;
          acc_d   = r_mod_m_i;
          cnt_d   = CNT_W'(EXP_WIDTH - 1);
          state_d = ST_PRE;
        end
      end
      ST_PRE:    state_d = ST_PRE_W;
      ST_PRE_W: begin
        if (mul_ok) begin
          xm_d    = prod;
          state_d = ST_SQ;
        end
      end
      ST_SQ:     state_d = ST_SQ_W;
      ST_SQ_W: begin
        if (mul_ok) begin
          acc_d   = prod;
          state_d = e_q[cnt_q] ? ST_MUL : ST_NEXT;
        end
      end
      ST_MUL:    state_d = ST_MUL_W;
      ST_MUL_W: begin
        if (mul_ok) begin
          acc_d   = prod;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (cnt_q == '0) begin
          state_d = ST_POST;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_SQ;
        end
      end
      ST_POST:   state_d = ST_POST_W;
      ST_POST_W: begin
        if (mul_ok) begin
          result_d = prod;
          state_d  = ST_DONE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    // Operands are loaded on entry to an issue state so they are valid alongside mul_start
    case (state_d)
      ST_PRE: begin
        mul_a_d = x_d;
        mul_b_d = r2_d;
      end
      ST_SQ: begin
        mul_a_d = acc_d;
        mul_b_d = acc_d;
      end
      ST_MUL: begin
        mul_a_d = acc_d;
        mul_b_d = xm_d;
      end
      ST_POST: begin
        mul_a_d = acc_d;
        mul_b_d = WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      acc_q    <= '0;
      xm_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      e_q      <= e_d;
      m_q      <= m_d;
      r2_q     <= r2_d;
      acc_q    <= acc_d;
      xm_q     <= xm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      armed_q  <= armed_d;
    end
  end

  assign result_o    = result_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_m_o     = m_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign mul_start_o = is_issue(state_q);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural Montgomery multiplier
// (random latency) and a plain-arithmetic x^e mod m reference.
module tb_modexp_ctrl;

  localparam int W     = 8;
  localparam int EW    = 8;
  localparam int M     = 13;
  localparam int RMOD  = 9;
  localparam int R2MOD = 3;

  logic          clk_i = 1'b0;
  logic          resetn_i, start_i;
  logic [W-1:0]  x_i, m_i, r_mod_m_i, r2_mod_m_i;
  logic [EW-1:0] e_i;
  logic [W-1:0]  result_o, mul_a_o, mul_b_o, mul_m_o;
  logic          done_o, busy_o, mul_start_o;
  logic [W+1:0]  mul_c_i;
  logic          mul_done_i;

  typedef struct {
    int res;
    int muls;
  } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   mulCnt = 0;
  int   resetEpoch = 0;
  int   lastResult = 0;
  logic prevMulStart = 1'b0;
  logic prevDone = 1'b0;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i),
    .x_i(x_i), .e_i(e_i), .m_i(m_i), .r_mod_m_i(r_mod_m_i), .r2_mod_m_i(r2_mod_m_i),
    .result_o(result_o), .done_o(done_o), .busy_o(busy_o),
    .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_m_o(mul_m_o),
    .mul_c_i(mul_c_i), .mul_done_i(mul_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Right-to-left binary exponentiation, independent of the DUT's bit order
  function automatic int modPow(input int x, input int e);
    int r = 1;
    int b = x % M;
    for (int i = 0; i < EW; i++) begin
      if ((e >> i) & 1) r = (r * b) % M;
      b = (b * b) % M;
    end
    return r;
  endfunction

  // Montgomery product a*b*R^-1 mod M, found by search over residues
  function automatic int montRef(input int a, input int b);
    for (int c = 0; c < M; c++)
      if (((c * (1 << W)) % M) == ((a * b) % M)) return c;
    return 0;
  endfunction

  // Behavioural multiplier: samples operands on mul_start, answers after random latency
  initial begin
    int capA, capB, lat, epoch;
    mul_done_i = 1'b0;
    mul_c_i    = '0;
    forever begin
      @(negedge clk_i);
      if (resetn_i && mul_start_o) begin
        capA  = int'(mul_a_o);
        capB  = int'(mul_b_o);
        epoch = resetEpoch;
        checkOutput("mul_m", int'(mul_m_o), M);
        mul_done_i = 1'b0;
        lat = $urandom_range(3, 20);
        repeat (lat - 1) @(negedge clk_i);
        if (epoch == resetEpoch) begin
          checkOutput("mul_a_stable", int'(mul_a_o), capA);
          checkOutput("mul_b_stable", int'(mul_b_o), capB);
        end
        mul_c_i    = (W+2)'(montRef(capA, capB));
        mul_done_i = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk_i) begin
    if (!resetn_i) begin
      mulCnt       = 0;
      prevMulStart = 1'b0;
      prevDone     = 1'b0;
      lastResult   = 0;
    end else begin
      if (mul_start_o) mulCnt++;
      checkOutput("mul_start_width", int'(prevMulStart & mul_start_o), 0);
      if (done_o) begin
        checkOutput("done_width", int'(prevDone), 0);
        checkOutput("busy_at_done", int'(busy_o), 1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", int'(done_o), 0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("result", int'(result_o), popped.res);
          checkOutput("mul_count", mulCnt, popped.muls);
        end
        lastResult = int'(result_o);
        mulCnt     = 0;
        doneCount++;
      end else if (busy_o) begin
        checkOutput("result_hold", int'(result_o), lastResult);
      end
      prevMulStart = mul_start_o;
      prevDone     = done_o;
    end
  end

  task automatic applyStimulus(input int x, input int e, input bit accept, input bit immediate);
    exp_t ex;
    if (!immediate) @(posedge clk_i);
    #1;
    x_i     = W'(x);
    e_i     = EW'(e);
    start_i = 1'b1;
    if (accept) begin
      ex.res  = modPow(x, e);
      ex.muls = 2 + EW + $countones(EW'(e));
      expQ.push_back(ex);
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    x_i     = W'($urandom);
    e_i     = EW'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int target = doneCount + 1;
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    checkOutput("done_timeout", int'(doneCount >= target), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_result"}, int'(result_o), 0);
    checkOutput({tag, "_mul_a"}, int'(mul_a_o), 0);
    checkOutput({tag, "_mul_b"}, int'(mul_b_o), 0);
    checkOutput({tag, "_mul_m"}, int'(mul_m_o), 0);
    checkOutput({tag, "_done"}, int'(done_o), 0);
    checkOutput({tag, "_busy"}, int'(busy_o), 0);
    checkOutput({tag, "_mul_start"}, int'(mul_start_o), 0);
  endtask

  initial begin
    int n;
    resetn_i   = 1'b1;
    start_i    = 1'b0;
    x_i        = '0;
    e_i        = '0;
    m_i        = W'(M);
    r_mod_m_i  = W'(RMOD);
    r2_mod_m_i = W'(R2MOD);
    #2 resetn_i = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) @(posedge clk_i);
    #1 resetn_i = 1'b1;

    applyStimulus(5, 3, 1, 0);    waitDone(2000);
    applyStimulus(7, 0, 1, 0);    waitDone(2000);
    applyStimulus(7, 1, 1, 0);    waitDone(2000);
    applyStimulus(0, 255, 1, 0);  waitDone(2000);
    applyStimulus(12, 2, 1, 0);   waitDone(2000);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(0, M - 1), $urandom_range(0, 255), 1, 0);
      waitDone(2000);
    end

    // Restarts while busy must leave the latched operands alone
    applyStimulus(9, 8'hFF, 1, 0);
    repeat (2) @(posedge clk_i);
    applyStimulus(4, 8'h11, 0, 0);
    checkOutput("busy_during_run", int'(busy_o), 1);
    repeat (45) @(posedge clk_i);
    applyStimulus(3, 8'h22, 0, 0);
    checkOutput("busy_late_run", int'(busy_o), 1);
    waitDone(2000);

    // Abort inside the first squaring wait
    applyStimulus(6, 8'hA5, 1, 0);
    n = 0;
    while (mulCnt < 2 && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    checkOutput("reach_sq_w", int'(mulCnt >= 2), 1);
    #3;
    resetn_i = 1'b0;
    resetEpoch++;
    expQ.delete();
    #1 checkResetOutputs("abort");
    repeat (2) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    repeat (30) @(posedge clk_i);
    #1 checkOutput("stale_done_busy", int'(busy_o), 0);
    checkOutput("stale_done_result", int'(result_o), 0);
    applyStimulus(5, 3, 1, 0);    waitDone(2000);

    // Back-to-back: new start in the cycle right after done
    applyStimulus(3, 5, 1, 0);    waitDone(2000);
    applyStimulus(11, 8'h9C, 1, 1);
    checkOutput("b2b_accepted", int'(busy_o), 1);
    waitDone(2000);

    repeat (3) @(posedge clk_i);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
